// File: rtl/turn_timer_pkg.sv
// Shared encodings for the GoBang turn timer: FSM states, player identity
// and the player digits shown on the seven-segment display.
package turn_timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    HALT   = 2'd3
  } state_t;

  typedef enum logic {
    BLACK = 1'b0,
    WHITE = 1'b1
  } player_t;

  localparam logic [3:0] PLAYER_DIGIT_BLACK = 4'd1;
  localparam logic [3:0] PLAYER_DIGIT_WHITE = 4'd2;

  function automatic logic [3:0] player_to_digit(input player_t p);
    return (p == WHITE) ? PLAYER_DIGIT_WHITE : PLAYER_DIGIT_BLACK;
  endfunction

  function automatic player_t other_player(input player_t p);
    return (p == WHITE) ? BLACK : WHITE;
  endfunction

endpackage

// File: rtl/bcd2_down_counter.sv
// Two-digit BCD down counter with synchronous load; zero_next flags the
// value 01 so the owner can reload instead of ever showing 00.
module bcd2_down_counter (
  input  logic       clk,
  input  logic       resetn,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_ones,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       zero_next
);

  always_ff @(posedge clk) begin
    if (!resetn || load) begin
      tens <= load_tens;
      ones <= load_ones;
    end else if (dec) begin
      if (ones != 4'd0) begin
        ones <= ones - 4'd1;
      end else if (tens != 4'd0) begin
        ones <= 4'd9;
        tens <= tens - 4'd1;
      end
    end
  end

  assign zero_next = (tens == 4'd0) && (ones == 4'd1);

endmodule

// File: rtl/turn_timer.sv
// Per-turn countdown timer: FSM, one-second prescaler and current player,
// driving the BCD seconds digits and player digit for the hex displays.
import turn_timer_pkg::*;

module turn_timer #(
  parameter int CLK_HZ    = 50000000,
  parameter int TURN_SECS = 30
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       move_done,
  input  logic       pause,
  input  logic       game_over,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] player_digit,
  output logic       timeout,
  output logic       running
);

  localparam int             PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [3:0]     LOAD_TENS  = 4'(TURN_SECS / 10);
  localparam logic [3:0]     LOAD_ONES  = 4'(TURN_SECS % 10);

  state_t        state, state_next;
  player_t       player, player_next;
  logic [PW-1:0] presc, presc_next;
  logic          load, dec, count_en, timeout_next, zero_next;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= IDLE;
      presc        <= '0;
      player       <= BLACK;
      player_digit <= PLAYER_DIGIT_BLACK;
      timeout      <= 1'b0;
      running      <= 1'b0;
    end else begin
      state        <= state_next;
      presc        <= presc_next;
      player       <= player_next;
      player_digit <= player_to_digit(player_next);
      timeout      <= timeout_next;
      running      <= (state_next == RUN);
    end
  end

  // Leaving PAUSED counts that cycle, so the prescaler resumes exactly
  // where it stopped rather than losing or gaining a cycle.
  always_comb begin
    state_next   = state;
    presc_next   = presc;
    player_next  = player;
    load         = 1'b0;
    dec          = 1'b0;
    count_en     = 1'b0;
    timeout_next = 1'b0;

    case (state)
      IDLE, HALT: begin
        if (start) begin
          state_next  = RUN;
          player_next = BLACK;
          presc_next  = '0;
          load        = 1'b1;
        end
      end
      RUN: begin
        if (game_over) begin
          state_next = HALT;
        end else if (pause) begin
          state_next = PAUSED;
        end else if (move_done) begin
          player_next = other_player(player);
          presc_next  = '0;
          load        = 1'b1;
        end else begin
          count_en = 1'b1;
        end
      end
      PAUSED: begin
        if (game_over) begin
          state_next = HALT;
        end else if (!pause) begin
          state_next = RUN;
          count_en   = 1'b1;
        end
      end
      default: ;
    endcase

    if (count_en) begin
      if (presc == PRESC_LAST) begin
        presc_next = '0;
        if (zero_next) begin
          load         = 1'b1;
          player_next  = other_player(player);
          timeout_next = 1'b1;
        end else begin
          dec = 1'b1;
        end
      end else begin
        presc_next = presc + PW'(1);
      end
    end
  end

  bcd2_down_counter u_digits (
    .clk       (clk),
    .resetn    (resetn),
    .load      (load),
    .dec       (dec),
    .load_tens (LOAD_TENS),
    .load_ones (LOAD_ONES),
    .tens      (sec_tens),
    .ones      (sec_ones),
    .zero_next (zero_next)
  );

endmodule

// File: tb/tb_turn_timer.sv
// Directed bench for turn_timer (CLK_HZ=4, TURN_SECS=12): the driver queues
// the expected outputs for every cycle, a negedge monitor pops and compares.
module tb_turn_timer;

  localparam int W = 15;
  // Input vector bits: {resetn, start, move_done, pause, game_over}
  localparam logic [4:0] NONE  = 5'b10000;
  localparam logic [4:0] RST   = 5'b00000;
  localparam logic [4:0] START = 5'b11000;
  localparam logic [4:0] MOVE  = 5'b10100;
  localparam logic [4:0] PAUSE = 5'b10010;
  localparam logic [4:0] PMOVE = 5'b10110;
  localparam logic [4:0] GO    = 5'b10001;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       move_done = 1'b0;
  logic       pause = 1'b0;
  logic       game_over = 1'b0;
  logic [3:0] sec_tens, sec_ones, player_digit;
  logic       timeout, running;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  logic [W-1:0] exp_e, got_e;
  string        exp_nm;
  int           check_cnt = 0;
  int           pass_cnt = 0;

  turn_timer #(.CLK_HZ(4), .TURN_SECS(12)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .move_done    (move_done),
    .pause        (pause),
    .game_over    (game_over),
    .sec_tens     (sec_tens),
    .sec_ones     (sec_ones),
    .player_digit (player_digit),
    .timeout      (timeout),
    .running      (running)
  );

  always #5 clk = ~clk;

  task automatic step(input logic [4:0] in, input logic chk,
                      input logic [3:0] t, input logic [3:0] o, input logic [3:0] p,
                      input logic to, input logic rn, input string nm);
    @(negedge clk);
    {resetn, start, move_done, pause, game_over} = in;
    @(posedge clk);
    #1;
    exp_q.push_back({chk, t, o, p, to, rn});
    name_q.push_back(nm);
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) step(NONE, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, "skip");
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_e  = exp_q.pop_front();
      exp_nm = name_q.pop_front();
      if (exp_e[W-1]) begin
        check_cnt++;
        got_e = {1'b1, sec_tens, sec_ones, player_digit, timeout, running};
        if (got_e === exp_e) pass_cnt++;
        else $display("FAIL %s: got tens=%0d ones=%0d player=%0d timeout=%b running=%b, want tens=%0d ones=%0d player=%0d timeout=%b running=%b",
                      exp_nm, sec_tens, sec_ones, player_digit, timeout, running,
                      exp_e[13:10], exp_e[9:6], exp_e[5:2], exp_e[1], exp_e[0]);
      end
    end
  end

  initial begin
    // Reset and idle behaviour
    step(RST,  1, 4'd1, 4'd2, 4'd1, 0, 0, "reset_1");
    step(RST,  1, 4'd1, 4'd2, 4'd1, 0, 0, "reset_2");
    step(NONE, 1, 4'd1, 4'd2, 4'd1, 0, 0, "idle_hold");
    step(MOVE, 1, 4'd1, 4'd2, 4'd1, 0, 0, "idle_move_ignored");
    step(PAUSE,1, 4'd1, 4'd2, 4'd1, 0, 0, "idle_pause_ignored");
    step(GO,   1, 4'd1, 4'd2, 4'd1, 0, 0, "idle_gameover_ignored");

    // Start and first decrements, including the 10 -> 09 borrow
    step(START, 1, 4'd1, 4'd2, 4'd1, 0, 1, "start");
    for (int i = 0; i < 3; i++) step(NONE, 1, 4'd1, 4'd2, 4'd1, 0, 1, "pre_tick");
    step(NONE, 1, 4'd1, 4'd1, 4'd1, 0, 1, "dec_11");
    wait_n(3);
    step(NONE, 1, 4'd1, 4'd0, 4'd1, 0, 1, "dec_10");
    wait_n(3);
    step(NONE, 1, 4'd0, 4'd9, 4'd1, 0, 1, "borrow_09");

    // Expiry at 48 cycles after start
    wait_n(31);
    step(NONE, 1, 4'd0, 4'd1, 4'd1, 0, 1, "digits_01");
    wait_n(3);
    step(NONE, 1, 4'd1, 4'd2, 4'd2, 1, 1, "expiry");
    step(NONE, 1, 4'd1, 4'd2, 4'd2, 0, 1, "timeout_one_cycle");
    wait_n(2);
    step(NONE, 1, 4'd1, 4'd1, 4'd2, 0, 1, "post_expiry_dec");

    // move_done at 03 with the prescaler mid-count
    wait_n(33);
    step(NONE, 1, 4'd0, 4'd3, 4'd2, 0, 1, "digits_03");
    step(MOVE, 1, 4'd1, 4'd2, 4'd1, 0, 1, "move_done");
    wait_n(2);
    step(NONE, 1, 4'd1, 4'd2, 4'd1, 0, 1, "move_hold");
    step(NONE, 1, 4'd1, 4'd1, 4'd1, 0, 1, "move_next_dec");

    // Pause after one prescaler cycle; move_done ignored while paused
    step(NONE, 1, 4'd1, 4'd1, 4'd1, 0, 1, "pre_pause");
    for (int i = 0; i < 10; i++)
      step((i == 4) ? PMOVE : PAUSE, 1, 4'd1, 4'd1, 4'd1, 0, 0, "paused");
    step(NONE, 1, 4'd1, 4'd1, 4'd1, 0, 1, "resume_1");
    step(NONE, 1, 4'd1, 4'd1, 4'd1, 0, 1, "resume_2");
    step(NONE, 1, 4'd1, 4'd0, 4'd1, 0, 1, "resume_dec");

    // move_done on the expiry cycle: one toggle, no timeout
    wait_n(39);
    step(MOVE, 1, 4'd1, 4'd2, 4'd2, 0, 1, "move_on_expiry");
    step(NONE, 1, 4'd1, 4'd2, 4'd2, 0, 1, "no_timeout");

    // game_over at 07, then held in HALT
    wait_n(19);
    step(GO, 1, 4'd0, 4'd7, 4'd2, 0, 0, "halt");
    for (int i = 0; i < 20; i++)
      step((i % 3 == 1) ? MOVE : ((i % 3 == 2) ? PAUSE : NONE), 1, 4'd0, 4'd7, 4'd2, 0, 0, "halt_hold");

    // Restart, start ignored in RUN, then reset mid-run
    step(START, 1, 4'd1, 4'd2, 4'd1, 0, 1, "restart");
    step(START, 1, 4'd1, 4'd2, 4'd1, 0, 1, "start_ignored");
    wait_n(2);
    step(NONE, 1, 4'd1, 4'd1, 4'd1, 0, 1, "dec_after_start_ignored");
    step(RST,  1, 4'd1, 4'd2, 4'd1, 0, 0, "reset_mid_run");
    step(NONE, 1, 4'd1, 4'd2, 4'd1, 0, 0, "idle_after_reset");

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      check_cnt++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
